// File: rtl/operand_entry_sequencer_if.sv
// Signal bundle between the operand entry sequencer and the multiplier datapath / front panel.
// master is the sequencer side; slave is the datapath/panel side.
interface operand_entry_sequencer_if;
   logic       enter;
   logic       inputdata_ready;
   logic       loaddata;
   logic       operand_sel;
   logic       start;
   logic       enter_pulse;
   logic       result_valid;
   logic       error;
   logic [2:0] state_dbg;

   modport master (
      input  enter, inputdata_ready,
      output loaddata, operand_sel, start, enter_pulse, result_valid, error, state_dbg
   );

   modport slave (
      output enter, inputdata_ready,
      input  loaddata, operand_sel, start, enter_pulse, result_valid, error, state_dbg
   );
endinterface

// File: rtl/operand_entry_sequencer.sv
// Button conditioning plus A/B operand entry, multiply start and result/timeout hold FSM.
// All outputs are registered; reset is asynchronous and active-low.
module operand_entry_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned TIMEOUT_CYCLES  = 64
) (
   input logic                        clk,
   input logic                        reset,
   operand_entry_sequencer_if.master  bus
);

   localparam int unsigned DbW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [2:0] {
      StWaitA   = 3'd0,
      StLoadA   = 3'd1,
      StWaitB   = 3'd2,
      StLoadB   = 3'd3,
      StCompute = 3'd4,
      StShow    = 3'd5,
      StError   = 3'd6
   } state_e;

   logic            sync1_q, sync2_q;
   logic            level_q, level_dly_q, pulse_q;
   logic [DbW-1:0]  db_cnt_q;
   logic [TmoW-1:0] tmo_q;
   state_e          state_q, state_d;
   logic            loaddata_q, operand_sel_q, start_q, result_valid_q, error_q;

   // Debounce: the level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         level_q     <= 1'b0;
         level_dly_q <= 1'b0;
         pulse_q     <= 1'b0;
         db_cnt_q    <= '0;
      end else begin
         sync1_q     <= bus.enter;
         sync2_q     <= sync1_q;
         level_dly_q <= level_q;
         pulse_q     <= level_q & ~level_dly_q;
         if (sync2_q == level_q) begin
            db_cnt_q <= '0;
         end else if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
            level_q  <= ~level_q;
            db_cnt_q <= '0;
         end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StWaitA:   if (pulse_q) state_d = StLoadA;
         StLoadA:   state_d = StWaitB;
         StWaitB:   if (pulse_q) state_d = StLoadB;
         StLoadB:   state_d = StCompute;
         StCompute: begin
            // Ready takes priority over a coincident timeout.
            if (bus.inputdata_ready) begin
               state_d = StShow;
            end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
               state_d = StError;
            end
         end
         StShow:    if (pulse_q) state_d = StWaitA;
         StError:   if (pulse_q) state_d = StWaitA;
         default:   state_d = StWaitA;
      endcase
   end

   // Outputs are decoded from the next state so they line up with state_q.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= StWaitA;
         tmo_q          <= '0;
         loaddata_q     <= 1'b0;
         operand_sel_q  <= 1'b0;
         start_q        <= 1'b0;
         result_valid_q <= 1'b0;
         error_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         tmo_q          <= (state_q == StCompute) ? tmo_q + 1'b1 : '0;
         loaddata_q     <= (state_d == StLoadA) || (state_d == StLoadB);
         operand_sel_q  <= (state_d == StWaitB) || (state_d == StLoadB);
         start_q        <= (state_q == StLoadB) && (state_d == StCompute);
         result_valid_q <= (state_d == StShow);
         error_q        <= (state_d == StError);
      end
   end

   assign bus.loaddata     = loaddata_q;
   assign bus.operand_sel  = operand_sel_q;
   assign bus.start        = start_q;
   assign bus.enter_pulse  = pulse_q;
   assign bus.result_valid = result_valid_q;
   assign bus.error        = error_q;
   assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_operand_entry_sequencer.sv
// Directed bench for operand_entry_sequencer with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=8.
module tb_operand_entry_sequencer;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   operand_entry_sequencer_if bus_if ();

   operand_entry_sequencer #(
      .DEBOUNCE_CYCLES (4),
      .TIMEOUT_CYCLES  (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] outs_vec();
      return {bus_if.loaddata, bus_if.operand_sel, bus_if.start, bus_if.enter_pulse,
              bus_if.result_valid, bus_if.error, bus_if.state_dbg[1:0]} |
             {5'b0, bus_if.state_dbg};
   endfunction

   task automatic do_reset();
      reset = 1'b0;
      bus_if.enter = 1'b0;
      bus_if.inputdata_ready = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
   endtask

   // Clean 4-cycle press; returns in the cycle enter_pulse is high (7 cycles after press).
   task automatic press(input string tag);
      int lat;
      lat = 99;
      bus_if.enter = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (i == 4) bus_if.enter = 1'b0;
         if (bus_if.enter_pulse === 1'b1) begin
            lat = i;
            break;
         end
      end
      bus_if.enter = 1'b0;
      chk(tag, 8'(lat), 8'd7);
   endtask

   // WAIT_A -> ... -> first COMPUTE cycle.
   task automatic go_compute();
      press("gc_press_a");
      tick();
      tick();
      tick();
      press("gc_press_b");
      tick();
      tick();
      chk("gc_state", 8'(bus_if.state_dbg), 8'd4);
      chk("gc_start", 8'(bus_if.start), 8'd1);
   endtask

   initial begin
      int pulses;
      bus_if.enter = 1'b0;
      bus_if.inputdata_ready = 1'b0;

      // 1. Reset with enter toggling
      for (int i = 0; i < 3; i++) begin
         bus_if.enter = i[0];
         tick();
         chk("rst_outs", outs_vec(), 8'h00);
      end
      bus_if.enter = 1'b0;
      reset = 1'b1;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         pulses += int'(bus_if.enter_pulse);
      end
      chk("rst_state", 8'(bus_if.state_dbg), 8'd0);
      chk("rst_nopulse", 8'(pulses), 8'd0);

      // 2. Bounce then stable high: single pulse on the 7th cycle
      do_reset();
      for (int i = 0; i < 4; i++) begin
         bus_if.enter = ~i[0];
         tick();
      end
      bus_if.enter = 1'b1;
      pulses = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         pulses += int'(bus_if.enter_pulse);
         if (i == 7) chk("db_pulse_at7", 8'(bus_if.enter_pulse), 8'd1);
      end
      chk("db_pulse_count", 8'(pulses), 8'd1);
      chk("db_state", 8'(bus_if.state_dbg), 8'd2);
      bus_if.enter = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      bus_if.enter = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      bus_if.enter = 1'b0;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         pulses += int'(bus_if.enter_pulse);
      end
      chk("glitch_nopulse", 8'(pulses), 8'd0);
      chk("glitch_state", 8'(bus_if.state_dbg), 8'd2);

      // 3. Normal flow, ready on 5th COMPUTE cycle
      do_reset();
      press("n_press_a");
      chk("n_wait_a", 8'(bus_if.state_dbg), 8'd0);
      tick();
      chk("n_load_a", {bus_if.state_dbg, bus_if.loaddata, bus_if.operand_sel}, {3'd1, 2'b10});
      tick();
      chk("n_wait_b", {bus_if.state_dbg, bus_if.loaddata, bus_if.operand_sel}, {3'd2, 2'b01});
      tick();
      press("n_press_b");
      tick();
      chk("n_load_b", {bus_if.state_dbg, bus_if.loaddata, bus_if.operand_sel}, {3'd3, 2'b11});
      tick();
      chk("n_c1", {bus_if.state_dbg, bus_if.loaddata, bus_if.start}, {3'd4, 2'b01});
      for (int i = 2; i <= 5; i++) begin
         tick();
         chk("n_cn", {bus_if.state_dbg, bus_if.loaddata, bus_if.start}, {3'd4, 2'b00});
      end
      bus_if.inputdata_ready = 1'b1;
      tick();
      bus_if.inputdata_ready = 1'b0;
      chk("n_show", {bus_if.state_dbg, bus_if.result_valid, bus_if.error}, {3'd5, 2'b10});
      press("n_press_ack");
      tick();
      chk("n_back", {bus_if.state_dbg, bus_if.result_valid}, {3'd0, 1'b0});

      // 4. Timeout after 8 COMPUTE cycles
      do_reset();
      go_compute();
      for (int i = 0; i < 7; i++) tick();
      chk("t_c8", {bus_if.state_dbg, bus_if.error}, {3'd4, 1'b0});
      tick();
      chk("t_err", {bus_if.state_dbg, bus_if.error, bus_if.result_valid}, {3'd6, 2'b10});
      bus_if.inputdata_ready = 1'b1;
      tick();
      tick();
      bus_if.inputdata_ready = 1'b0;
      chk("t_err_hold", 8'(bus_if.state_dbg), 8'd6);
      press("t_press_ack");
      tick();
      chk("t_back", {bus_if.state_dbg, bus_if.error}, {3'd0, 1'b0});

      // 5. Ready on exactly the 8th cycle, press dropped during COMPUTE
      do_reset();
      go_compute();
      bus_if.enter = 1'b1;
      for (int i = 2; i <= 8; i++) begin
         tick();
         if (i == 5) bus_if.enter = 1'b0;
      end
      chk("b_c8_state", 8'(bus_if.state_dbg), 8'd4);
      chk("b_c8_pulse", 8'(bus_if.enter_pulse), 8'd1);
      bus_if.inputdata_ready = 1'b1;
      tick();
      bus_if.inputdata_ready = 1'b0;
      chk("b_show", {bus_if.state_dbg, bus_if.error, bus_if.result_valid}, {3'd5, 2'b01});
      for (int i = 0; i < 4; i++) tick();
      chk("b_no_queue", 8'(bus_if.state_dbg), 8'd5);
      press("b_press_ack");
      tick();
      bus_if.inputdata_ready = 1'b1;
      tick();
      tick();
      bus_if.inputdata_ready = 1'b0;
      tick();
      chk("b_rdy_wait_a", 8'(bus_if.state_dbg), 8'd0);

      // 6. Reset in COMPUTE
      do_reset();
      go_compute();
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("m_async_outs", outs_vec(), 8'h00);
      tick();
      tick();
      reset = 1'b1;
      tick();
      chk("m_state", 8'(bus_if.state_dbg), 8'd0);
      go_compute();
      bus_if.inputdata_ready = 1'b1;
      tick();
      bus_if.inputdata_ready = 1'b0;
      chk("m_show", {bus_if.state_dbg, bus_if.result_valid}, {3'd5, 1'b1});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/operand_entry_sequencer.md
Name: operand_entry_sequencer

Overview:
Control stage directly upstream of the multiplier datapath.
- Conditions the raw "enter" push-button: synchronise, debounce, edge-detect.
- Sequences entry of operand A, then operand B, via loaddata/operand_sel.
- Starts the multiply, waits for the datapath's inputdata_ready, and holds result/error status until the user acknowledges with another press.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive cycles the synchronised button must differ from the current debounced level before that level flips (minimum 2).
TIMEOUT_CYCLES, 64, maximum cycles spent in COMPUTE waiting for inputdata_ready before flagging an error (minimum 2).

Ports:
clk  input  1  system clock; all logic is rising-edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
enter  input  1  raw push-button, active-high, asynchronous, may bounce.
inputdata_ready  input  1  datapath result-ready flag, sampled only in COMPUTE.
loaddata  output  1  one-cycle operand load strobe to the datapath.
operand_sel  output  1  0 = operand A being entered, 1 = operand B.
start  output  1  one-cycle multiply start strobe.
enter_pulse  output  1  one-cycle debounced press pulse, exported for the datapath.
result_valid  output  1  high while the product is displayed.
error  output  1  high while in the timeout error state.
state_dbg  output  3  current FSM state encoding.

Behaviour:
Reset
- reset=0 asynchronously clears all flops; outputs 0 in the same instant.
- Clears the synchroniser, debounced level, debounce counter, timeout counter and FSM; FSM enters WAIT_A.
- Every output reads 0 while reset is held, including state_dbg=0.
- Deassertion mid-operation restarts at WAIT_A; no partial state is retained.

Input conditioning
- Two-flop synchroniser on enter.
- Debounce counter increments each cycle the synchronised value differs from the debounced level.
- Counter clears whenever the synchronised value equals the debounced level.
- On reaching DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- enter_pulse is a registered pulse, high exactly one cycle on each 0->1 of the debounced level; release generates nothing.
- Latency: enter held high from edge k gives enter_pulse high in the cycle after edge k+2+DEBOUNCE_CYCLES.
- Glitches shorter than DEBOUNCE_CYCLES produce no pulse.

FSM (Moore outputs, one state per cycle unless waiting)
- Encoding: WAIT_A=0, LOAD_A=1, WAIT_B=2, LOAD_B=3, COMPUTE=4, SHOW=5, ERROR=6; 7 is unreachable and recovers to WAIT_A.
- WAIT_A: operand_sel=0. enter_pulse -> LOAD_A.
- LOAD_A: loaddata=1, operand_sel=0. Unconditional -> WAIT_B.
- WAIT_B: operand_sel=1. enter_pulse -> LOAD_B.
- LOAD_B: loaddata=1, operand_sel=1. Unconditional -> COMPUTE; timeout counter cleared.
- COMPUTE: start=1 on the first COMPUTE cycle only. Timeout counter increments each cycle.
  - inputdata_ready=1 -> SHOW. Ready wins if it coincides with timeout.
  - Counter reaching TIMEOUT_CYCLES-1 with ready=0 -> ERROR.
- SHOW: result_valid=1. enter_pulse -> WAIT_A.
- ERROR: error=1. enter_pulse -> WAIT_A.
- enter_pulse is dropped (not queued) in LOAD_A, LOAD_B and COMPUTE.
- inputdata_ready is ignored in every state except COMPUTE.
- loaddata, start, result_valid and error are mutually exclusive; loaddata is never high for more than one consecutive cycle.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with enter toggling -> all outputs 0, state_dbg=0; after release, state_dbg=0 and no enter_pulse.
2. Debounce (DEBOUNCE_CYCLES=4): enter bounces 1,0,1,0 each cycle, then held high 10 cycles -> exactly one enter_pulse, in the cycle after edge k+6 counting from the start of the stable high; a 3-cycle glitch -> no pulse.
3. Normal flow: press, press, then drive inputdata_ready=1 on the 5th COMPUTE cycle ->
   - state_dbg sequence 0,1,2,3,4..4,5.
   - loaddata high in exactly two single cycles, operand_sel 0 then 1.
   - start high only in the first COMPUTE cycle; result_valid=1 in SHOW.
   - A third press -> state_dbg=0.
4. Timeout (TIMEOUT_CYCLES=8): inputdata_ready never asserted -> ERROR after 8 COMPUTE cycles, error=1; press -> WAIT_A, error=0.
5. Boundary: inputdata_ready=1 on exactly the 8th COMPUTE cycle -> SHOW, not ERROR. Presses during COMPUTE are ignored, state stays 4. Ready pulses in WAIT_A do not change state.
6. Mid-operation reset: assert reset=0 while in COMPUTE -> outputs 0 immediately; after release, state_dbg=0 and a full A/B/compute sequence completes normally.
